// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU constants for the register-file writeback path.
// Holds the write-port bundle type used by the arbiter output register.
package regfile_wb_arbiter_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              from_b;
  } wb_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write mask for long-latency destinations: reservation on issue,
// release when the B writeback lands, and combinational hazard lookup.
module regfile_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_addr,
  output logic              iss_ready,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic              busy1,
  output logic              busy2
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                set_en;

  // Bit 0 is never set, so a zero address always sees ready and never busy.
  always_comb begin
    iss_ready = !rst && !pending_q[iss_addr];
    set_en    = iss_valid && iss_ready && (iss_addr != '0);
    pending_d = pending_q;
    if (clr_en) pending_d[clr_addr] = 1'b0;
    if (set_en) pending_d[iss_addr] = 1'b1;
    busy1 = (ra1 != '0) && pending_q[ra1];
    busy2 = (ra2 != '0) && pending_q[ra2];
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter into the register-file write port.
// A wins by default; B is forced through after STARVE_LIMIT refused cycles.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [REG_AW-1:0] iss_addr,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic              busy1,
  output logic              busy2,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd
);

  logic [3:0] starve_q, starve_d;
  wb_t        wb_q, wb_d;
  logic       force_b;
  logic       a_acc, b_acc;

  always_comb begin
    force_b = starve_q >= 4'(STARVE_LIMIT);
    a_ready = !rst && !force_b;
    b_ready = !rst && (force_b || !a_valid);
    a_acc   = a_valid && a_ready;
    b_acc   = b_valid && b_ready;

    starve_d = starve_q;
    if (!b_valid || b_ready)    starve_d = '0;
    else if (starve_q != 4'hF)  starve_d = starve_q + 4'd1;

    // a_acc and b_acc are mutually exclusive by construction of the readies.
    wb_d        = wb_q;
    wb_d.we     = 1'b0;
    wb_d.from_b = 1'b0;
    if (a_acc) begin
      wb_d.we = (a_addr != '0);
      wb_d.wa = a_addr;
      wb_d.wd = a_data;
    end else if (b_acc) begin
      wb_d.we     = (b_addr != '0);
      wb_d.wa     = b_addr;
      wb_d.wd     = b_data;
      wb_d.from_b = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      wb_q     <= '0;
    end else begin
      starve_q <= starve_d;
      wb_q     <= wb_d;
    end
  end

  assign rf_we = wb_q.we;
  assign rf_wa = wb_q.wa;
  assign rf_wd = wb_q.wd;

  regfile_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .clr_en    (wb_q.we && wb_q.from_b),
    .clr_addr  (wb_q.wa),
    .ra1       (ra1),
    .ra2       (ra2),
    .busy1     (busy1),
    .busy2     (busy2)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: cycle model predicts readies, hazards and
// pending mask; expected write-port values go through a queue one cycle deep.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid, b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_addr;
  logic [4:0]  ra1, ra2;
  logic        busy1, busy2;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  regfile_wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_addr(iss_addr),
    .ra1(ra1), .ra2(ra2), .busy1(busy1), .busy2(busy2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  wb_t         exp_q[$];
  logic [31:0] m_pend   = '0;
  logic [3:0]  m_starve = '0;
  logic        last_b_acc;
  logic        obs_a_ready, obs_b_ready, obs_iss_ready, obs_busy1, obs_rf_we;
  logic [4:0]  obs_rf_wa;
  logic [31:0] obs_rf_wd, obs_pend;
  logic [3:0]  obs_starve;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // return just after the rising edge so the caller can drive new inputs.
  task automatic step();
    wb_t  e, n;
    logic f, ar, br, ir, aacc, bacc, iacc;
    @(negedge clk);
    obs_a_ready = a_ready; obs_b_ready = b_ready; obs_iss_ready = iss_ready;
    obs_busy1 = busy1; obs_rf_we = rf_we; obs_rf_wa = rf_wa; obs_rf_wd = rf_wd;
    obs_pend = dut.u_sb.pending_q; obs_starve = dut.starve_q;
    e = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("rf_we", 32'(rf_we), 32'(e.we));
      if (e.we) begin
        check_eq("rf_wa", 32'(rf_wa), 32'(e.wa));
        check_eq("rf_wd", rf_wd, e.wd);
      end
    end
    check_eq("pending", obs_pend, m_pend);
    check_eq("starve", 32'(obs_starve), 32'(m_starve));
    f  = (m_starve >= 4'd3);
    ar = !rst && !f;
    br = !rst && (f || !a_valid);
    ir = !rst && !((iss_addr != 5'd0) && m_pend[iss_addr]);
    check_eq("a_ready", 32'(a_ready), 32'(ar));
    check_eq("b_ready", 32'(b_ready), 32'(br));
    check_eq("iss_ready", 32'(iss_ready), 32'(ir));
    check_eq("busy1", 32'(busy1), 32'((ra1 != 5'd0) && m_pend[ra1]));
    check_eq("busy2", 32'(busy2), 32'((ra2 != 5'd0) && m_pend[ra2]));
    aacc = a_valid && ar;
    bacc = b_valid && br;
    iacc = iss_valid && ir;
    n = '0;
    if (!rst) begin
      if (aacc) begin
        n.we = (a_addr != 5'd0); n.wa = a_addr; n.wd = a_data;
      end else if (bacc) begin
        n.we = (b_addr != 5'd0); n.wa = b_addr; n.wd = b_data; n.from_b = 1'b1;
      end
    end
    exp_q.push_back(n);
    if (rst) begin
      m_pend   = '0;
      m_starve = '0;
    end else begin
      if (e.we && e.from_b) m_pend[e.wa] = 1'b0;
      if (iacc && iss_addr != 5'd0) m_pend[iss_addr] = 1'b1;
      if (!b_valid || br)          m_starve = '0;
      else if (m_starve != 4'hF)   m_starve = m_starve + 4'd1;
    end
    last_b_acc = bacc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  refused;
    logic got;
    rst = 1'b1;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    iss_valid = 0; iss_addr = 0; ra1 = 0; ra2 = 0;
    last_b_acc = 0;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    step();
    check_eq("reset_rf_we", 32'(obs_rf_we), 32'd0);
    check_eq("reset_rf_wd", obs_rf_wd, 32'd0);

    // A-only write lands one cycle later
    a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    step();
    check_eq("a_only_ready", 32'(obs_a_ready), 32'd1);
    a_valid = 0;
    step();
    check_eq("a_only_we", 32'(obs_rf_we), 32'd1);
    check_eq("a_only_wa", 32'(obs_rf_wa), 32'd5);
    check_eq("a_only_wd", obs_rf_wd, 32'hDEADBEEF);

    // B starved behind a continuous A stream
    a_valid = 1; b_valid = 1; b_addr = 3; b_data = 32'hB0B00003;
    refused = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      a_addr = 5'(i + 10); a_data = 32'(i + 100);
      step();
      if (obs_b_ready) begin
        got = 1;
        check_eq("force_a_blocked", 32'(obs_a_ready), 32'd0);
      end else begin
        refused++;
      end
    end
    check_eq("starve_refused", 32'(refused), 32'd3);
    b_valid = 0;
    step();
    check_eq("a_regrant", 32'(obs_a_ready), 32'd1);
    a_valid = 0;
    step();

    // WAW stall on reg 7 until the B write releases it
    iss_valid = 1; iss_addr = 7; ra1 = 7;
    step();
    step();
    check_eq("busy7", 32'(obs_busy1), 32'd1);
    check_eq("waw_stall", 32'(obs_iss_ready), 32'd0);
    b_valid = 1; b_addr = 7; b_data = 32'h77777777;
    step();
    b_valid = 0;
    step();
    check_eq("b7_we", 32'(obs_rf_we), 32'd1);
    check_eq("busy7_during_we", 32'(obs_busy1), 32'd1);
    step();
    check_eq("busy7_cleared", 32'(obs_busy1), 32'd0);
    check_eq("reissue7", 32'(obs_iss_ready), 32'd1);
    iss_valid = 0;
    step();
    check_eq("busy7_reset_by_issue", 32'(obs_busy1), 32'd1);
    b_valid = 1; b_addr = 7; b_data = 32'h70707070;
    step();
    b_valid = 0;
    step();
    step();

    // zero address: accepted, never written, never reserved
    a_valid = 1; a_addr = 0; a_data = 32'h12345678;
    iss_valid = 1; iss_addr = 0;
    step();
    check_eq("a0_ready", 32'(obs_a_ready), 32'd1);
    a_valid = 0; iss_valid = 0;
    step();
    check_eq("a0_no_we", 32'(obs_rf_we), 32'd0);
    check_eq("iss0_pend", obs_pend, 32'h0);

    // same-edge clear and reservation of reg 9: set wins
    b_valid = 1; b_addr = 9; b_data = 32'h99999999;
    step();
    b_valid = 0; iss_valid = 1; iss_addr = 9;
    step();
    check_eq("b9_we", 32'(obs_rf_we), 32'd1);
    iss_valid = 0;
    step();
    check_eq("same_edge_9", 32'(obs_pend[9]), 32'd1);
    b_valid = 1; b_addr = 9; b_data = 32'h90909090;
    step();
    b_valid = 0;
    step();
    step();

    // reset with pending 0x90, a nonzero counter and a write in flight
    iss_valid = 1; iss_addr = 4;
    step();
    iss_addr = 7;
    step();
    iss_valid = 0;
    a_valid = 1; a_addr = 20; a_data = 32'hA5A5A5A5;
    b_valid = 1; b_addr = 12; b_data = 32'hC0C0C0C0;
    step();
    step();
    check_eq("pend_pre_rst", obs_pend, 32'h90);
    rst = 1;
    step();
    check_eq("rst_inflight_we", 32'(obs_rf_we), 32'd1);
    rst = 0; a_valid = 0; b_valid = 0;
    step();
    check_eq("post_rst_we", 32'(obs_rf_we), 32'd0);
    check_eq("post_rst_pend", obs_pend, 32'h0);
    check_eq("post_rst_starve", 32'(obs_starve), 32'd0);

    // random traffic; B holds its request until accepted
    for (int c = 0; c < 400; c++) begin
      a_valid = 1'($urandom_range(0, 1));
      a_addr  = 5'($urandom_range(0, 31));
      a_data  = $urandom;
      if (!b_valid || last_b_acc) begin
        b_valid = 1'($urandom_range(0, 1));
        b_addr  = 5'($urandom_range(0, 7));
        b_data  = $urandom;
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_addr  = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      ra2 = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0; a_valid = 0; b_valid = 0; iss_valid = 0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
